hash_search_ctrl: RTL and testbench

HASH_SEARCH_CTRL -- requirements
Module: hash_search_ctrl

---
 rtl/hash_search_pkg.sv | 42 ++++
 rtl/hit_select.sv | 25 ++
 rtl/hash_search_ctrl.sv | 128 ++++++++++++
 tb/tb_hash_search_ctrl.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/hash_search_pkg.sv
// rtl/hash_search_pkg.sv - shared state encoding and elaboration-time helpers for hash_search_ctrl
package hash_search_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LAUNCH = 3'd1,
        ST_RUN    = 3'd2,
        ST_HIT    = 3'd3,
        ST_MISS   = 3'd4
    } state_t;

    // Widest ASCII value the helpers produce: 12 digits of 8 bits
    localparam int ASCII_MAX_W = 96;
    localparam int COUNT_W     = 40;

    // 10^digits; used only at elaboration time
    function automatic longint unsigned pow10(input int digits);
        longint unsigned p;
        p = 64'd1;
        for (int i = 0; i < digits; i++) begin
            p = p * 64'd10;
        end
        return p;
    endfunction

    // Zero-padded ASCII decimal, least significant digit in the lowest byte
    function automatic logic [ASCII_MAX_W-1:0] dec_to_ascii(input longint unsigned value,
                                                            input int digits);
        logic [ASCII_MAX_W-1:0] res;
        longint unsigned        v;
        res = '0;
        v   = value;
        for (int i = 0; i < ASCII_MAX_W / 8; i++) begin
            if (i < digits) begin
                res[i*8 +: 8] = 8'h30 + 8'(v % 64'd10);
                v             = v / 64'd10;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/hit_select.sv
// rtl/hit_select.sv - lowest-index priority select of engine match flags and passwords
module hit_select
    import hash_search_pkg::*;
#(
    parameter int NUM_ENG = 6,
    parameter int W       = 72
) (
    input  logic [NUM_ENG-1:0]   found_in,
    input  logic [NUM_ENG*W-1:0] pwd_in,
    output logic                 any_found,
    output logic [W-1:0]         sel_pwd
);

    // Scan from the top so the lowest-index matching engine is written last and wins
    always_comb begin
        any_found = |found_in;
        sel_pwd   = '0;
        for (int i = NUM_ENG - 1; i >= 0; i--) begin
            if (found_in[i]) begin
                sel_pwd = pwd_in[i*W +: W];
            end
        end
    end

endmodule

// File: rtl/hash_search_ctrl.sv
// rtl/hash_search_ctrl.sv - password search controller over parallel hash engines; optional HASH_SEARCH_TIMEOUT_EN
module hash_search_ctrl
    import hash_search_pkg::*;
#(
    parameter int NUM_ENG = 6,
    parameter int DIGITS  = 9,
    parameter int TIMER_W = 56
`ifdef HASH_SEARCH_TIMEOUT_EN
    ,
    parameter longint unsigned TIMEOUT = 64'hFFFF_FFFF
`endif
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        start,
    input  logic                        abort,
    output logic [NUM_ENG-1:0]          eng_go,
    output logic [NUM_ENG*DIGITS*8-1:0] eng_base,
    output logic [NUM_ENG*COUNT_W-1:0]  eng_count,
    input  logic [NUM_ENG-1:0]          eng_found,
    input  logic [NUM_ENG-1:0]          eng_empty,
    input  logic [NUM_ENG*DIGITS*8-1:0] eng_pwd,
    output logic                        busy,
    output logic                        found,
    output logic                        not_found,
    output logic [DIGITS*8-1:0]         pwd_out,
    output logic [TIMER_W-1:0]          cycles
);

    localparam int              DW    = DIGITS * 8;
    localparam longint unsigned SPACE = pow10(DIGITS);
    localparam longint unsigned CHUNK = SPACE / longint'(NUM_ENG);
    localparam longint unsigned REM   = SPACE - CHUNK * longint'(NUM_ENG);

    state_t             state;
    state_t             state_nxt;
    logic               any_found;
    logic [DW-1:0]      sel_pwd;
    logic [TIMER_W-1:0] cycles_inc;
    logic               timed_out;

    // Each engine owns a contiguous slice; the last one also takes the remainder
    for (genvar i = 0; i < NUM_ENG; i++) begin : g_eng
        localparam logic [ASCII_MAX_W-1:0] BASE_ASCII =
            dec_to_ascii(longint'(i) * CHUNK, DIGITS);
        assign eng_base[i*DW +: DW] = BASE_ASCII[DW-1:0];
        assign eng_count[i*COUNT_W +: COUNT_W] =
            (i == NUM_ENG - 1) ? COUNT_W'(CHUNK + REM) : COUNT_W'(CHUNK);
    end

    hit_select #(
        .NUM_ENG (NUM_ENG),
        .W       (DW)
    ) u_hit_select (
        .found_in  (eng_found),
        .pwd_in    (eng_pwd),
        .any_found (any_found),
        .sel_pwd   (sel_pwd)
    );

    assign cycles_inc = (&cycles) ? cycles : cycles + 1'b1;

`ifdef HASH_SEARCH_TIMEOUT_EN
    assign timed_out = (cycles_inc == TIMER_W'(TIMEOUT));
`else
    assign timed_out = 1'b0;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and status outputs; a match always beats exhaustion, abort and timeout
    always_comb begin
        state_nxt = state;
        eng_go    = '0;
        busy      = 1'b0;
        found     = 1'b0;
        not_found = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) state_nxt = ST_LAUNCH;
            end
            ST_LAUNCH: begin
                eng_go    = '1;
                busy      = 1'b1;
                state_nxt = ST_RUN;
            end
            ST_RUN: begin
                busy = 1'b1;
                if (any_found) begin
                    state_nxt = ST_HIT;
                end else if ((&eng_empty) || abort || timed_out) begin
                    state_nxt = ST_MISS;
                end
            end
            ST_HIT: begin
                found = 1'b1;
                if (start) state_nxt = ST_IDLE;
            end
            ST_MISS: begin
                not_found = 1'b1;
                if (start) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Cycle counter and captured password; cleared on entry to LAUNCH, frozen outside RUN
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cycles  <= '0;
            pwd_out <= '0;
        end else if (state_nxt == ST_LAUNCH) begin
            cycles  <= '0;
            pwd_out <= '0;
        end else if (state == ST_RUN) begin
            cycles <= cycles_inc;
            if (any_found) pwd_out <= sel_pwd;
        end
    end

endmodule

// File: tb/tb_hash_search_ctrl.sv
// tb/tb_hash_search_ctrl.sv - directed self-checking bench for hash_search_ctrl
module tb_hash_search_ctrl;

    localparam int NUM_ENG = 6;
    localparam int DIGITS  = 9;
    localparam int TIMER_W = 56;
    localparam int DW      = DIGITS * 8;

    logic                    clk = 1'b0;
    logic                    reset_n = 1'b0;
    logic                    start = 1'b0;
    logic                    abort = 1'b0;
    logic [NUM_ENG-1:0]      eng_go;
    logic [NUM_ENG*DW-1:0]   eng_base;
    logic [NUM_ENG*40-1:0]   eng_count;
    logic [NUM_ENG-1:0]      eng_found = '0;
    logic [NUM_ENG-1:0]      eng_empty = '0;
    logic [NUM_ENG*DW-1:0]   eng_pwd = '0;
    logic                    busy;
    logic                    found;
    logic                    not_found;
    logic [DW-1:0]           pwd_out;
    logic [TIMER_W-1:0]      cycles;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    hash_search_ctrl #(
        .NUM_ENG (NUM_ENG),
        .DIGITS  (DIGITS),
        .TIMER_W (TIMER_W)
`ifdef HASH_SEARCH_TIMEOUT_EN
        ,
        .TIMEOUT (64'd50)
`endif
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .abort     (abort),
        .eng_go    (eng_go),
        .eng_base  (eng_base),
        .eng_count (eng_count),
        .eng_found (eng_found),
        .eng_empty (eng_empty),
        .eng_pwd   (eng_pwd),
        .busy      (busy),
        .found     (found),
        .not_found (not_found),
        .pwd_out   (pwd_out),
        .cycles    (cycles)
    );

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_pwd(input int idx, input logic [DW-1:0] val);
        eng_pwd[idx*DW +: DW] = val;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    logic [DW-1:0] s0 = "000000000";
    logic [DW-1:0] s3 = "499999998";
    logic [DW-1:0] s5 = "833333330";
    logic [DW-1:0] p2 = "123456789";
    logic [DW-1:0] p1 = "111111111";
    logic [DW-1:0] p4 = "444444444";

    initial begin
        // Reset
        tick(2);
        reset_n = 1'b1;
        check("rst_busy", 128'(busy), 128'd0);
        check("rst_flags", 128'({found, not_found}), 128'd0);
        check("rst_eng_go", 128'(eng_go), 128'd0);
        check("rst_cycles", 128'(cycles), 128'd0);
        check("rst_pwd", 128'(pwd_out), 128'd0);

        // Range split: chunk 166666666, last engine spans 833333330..999999999
        check("base0", 128'(eng_base[0*DW +: DW]), 128'(s0));
        check("base3", 128'(eng_base[3*DW +: DW]), 128'(s3));
        check("base5", 128'(eng_base[5*DW +: DW]), 128'(s5));
        check("count0", 128'(eng_count[0*40 +: 40]), 128'd166666666);
        check("count5", 128'(eng_count[5*40 +: 40]), 128'd166666670);

        // Single hit after 100 RUN cycles
        pulse_start();
        check("launch_go", 128'(eng_go), 128'h3f);
        check("launch_busy", 128'(busy), 128'd1);
        tick();
        check("run_go_low", 128'(eng_go), 128'd0);
        tick(99);
        eng_found = 6'b000100;
        set_pwd(2, p2);
        tick();
        eng_found = '0;
        check("hit_found", 128'({found, not_found, busy}), 128'b100);
        check("hit_pwd", 128'(pwd_out), 128'(p2));
        check("hit_cycles", 128'(cycles), 128'd100);
        tick(3);
        check("hit_cycles_frozen", 128'(cycles), 128'd100);
        pulse_start();
        check("idle_keep_pwd", 128'(pwd_out), 128'(p2));
        check("idle_keep_cycles", 128'(cycles), 128'd100);
        check("idle_flags", 128'({found, busy}), 128'd0);

        // Engines 1 and 4 match together while everything is also empty
        pulse_start();
        check("launch_clr_pwd", 128'(pwd_out), 128'd0);
        check("launch_clr_cycles", 128'(cycles), 128'd0);
        tick();
        eng_found = 6'b010010;
        eng_empty = '1;
        set_pwd(1, p1);
        set_pwd(4, p4);
        tick();
        eng_found = '0;
        eng_empty = '0;
        check("prio_found", 128'({found, not_found}), 128'b10);
        check("prio_pwd", 128'(pwd_out), 128'(p1));
        pulse_start();

        // Exhaustion, with a start during RUN that must be ignored
        pulse_start();
        tick();
        pulse_start();
        check("run_start_ignored", 128'(busy), 128'd1);
        eng_empty = '1;
        tick();
        eng_empty = '0;
        check("miss_flags", 128'({found, not_found, busy}), 128'b010);
        check("miss_cycles", 128'(cycles), 128'd2);
        pulse_start();

        // Abort
        pulse_start();
        tick(5);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_flags", 128'({found, not_found, busy}), 128'b010);
        check("abort_cycles", 128'(cycles), 128'd5);
        pulse_start();

        // Reset mid-RUN
        pulse_start();
        tick(10);
        check("pre_rst_busy", 128'(busy), 128'd1);
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        check("midrun_rst_flags", 128'({busy, found, not_found}), 128'd0);
        check("midrun_rst_cycles", 128'(cycles), 128'd0);
        check("midrun_rst_go", 128'(eng_go), 128'd0);
        check("rst_base_kept", 128'(eng_base[3*DW +: DW]), 128'(s3));

`ifdef HASH_SEARCH_TIMEOUT_EN
        // Timeout with no engine response
        begin
            int budget;
            pulse_start();
            tick();
            budget = 200;
            while (!not_found && budget > 0) begin
                tick();
                budget--;
            end
            check("timeout_reached", 128'(not_found), 128'd1);
            check("timeout_cycles", 128'(cycles), 128'd50);
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
